driver_74lv165_chain: RTL and testbench

- Parametrised reader for N_CH parallel chains of daisy-chained 74LV165 PISO shift registers. Each chain is WIDTH bits long.
- Generates the shared load and serial-clock strobes and deserialises the QH inputs. Presents a stable, optionally glitch-filtered parallel snapshot to the core logic.
- Supports two modes: continuous scan, and one-shot scan on request.
- Flags every committed frame that differs from the previous committed frame.

---
 rtl/driver_74lv165_chain.sv | 119 +++++++++++
 tb/tb_driver_74lv165_chain.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_74lv165_chain.sv
// Reader for N_CH parallel chains of daisy-chained 74LV165 PISO registers: drives the shared
// SH/LD# and CLK strobes, deserialises QH and commits an optionally glitch-filtered snapshot.
module driver_74lv165_chain #(
   parameter int N_CH  = 3,
   parameter int WIDTH = 24,
   parameter int DIV   = 1,
   parameter int FILT  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  oneshot,
   input  logic                  start,
   output logic                  sh_ldn,
   output logic                  sclk,
   input  logic [N_CH-1:0]       qh,
   output logic [N_CH*WIDTH-1:0] data,
   output logic                  data_valid,
   output logic                  frame_done,
   output logic                  changed,
   output logic                  busy,
   output logic [2:0]            state_dbg
);
   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = $clog2(WIDTH + 1);
   localparam int MW = (FILT > 1) ? $clog2(FILT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
   localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);
   localparam logic [MW-1:0] M_MAX  = MW'(FILT - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SAMPLE, S_CLKHI, S_COMMIT} state_t;

   state_t                state_q, state_n;
   logic [TW-1:0]         timer_q;
   logic [BW-1:0]         bit_cnt_q;
   logic [MW-1:0]         match_q, match_n;
   logic [N_CH*WIDTH-1:0] shift_q, hist_q, captured;
   logic                  phase_end, sample_now, commit_now, do_commit;

   assign state_dbg = state_q;

   // Handshake: start is a one-cycle request honoured only while IDLE (never queued);
   // frame_done and changed are one-cycle pulses with no back-pressure from the core.
   always_comb begin
      phase_end  = (timer_q == T_LAST);
      sample_now = (state_q == S_SAMPLE) && phase_end;
      commit_now = sample_now && (bit_cnt_q == B_LAST);
      state_n    = state_q;
      case (state_q)
         S_IDLE:   if (enable && (!oneshot || start)) state_n = S_LOAD;
         S_LOAD:   if (phase_end) state_n = S_SAMPLE;
         S_SAMPLE: if (phase_end) state_n = commit_now ? S_COMMIT : S_CLKHI;
         S_CLKHI:  if (phase_end) state_n = S_SAMPLE;
         S_COMMIT: state_n = (enable && !oneshot) ? S_LOAD : S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // The frame is evaluated on the final sample edge so the commit lands in the COMMIT cycle.
   always_comb begin
      captured = '0;
      for (int c = 0; c < N_CH; c++)
         captured[c*WIDTH +: WIDTH] = {shift_q[c*WIDTH +: WIDTH-1], qh[c]};
      if (captured == hist_q)
         match_n = (match_q == M_MAX) ? M_MAX : match_q + MW'(1);
      else
         match_n = '0;
      do_commit = (match_n == M_MAX);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         sh_ldn    <= 1'b1;
         sclk      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q <= state_n;
         if (state_q == S_IDLE || state_n != state_q)
            timer_q <= '0;
         else
            timer_q <= timer_q + TW'(1);
         if (state_q == S_LOAD)
            bit_cnt_q <= '0;
         else if (sample_now)
            bit_cnt_q <= bit_cnt_q + BW'(1);
         sh_ldn <= (state_n != S_LOAD);
         sclk   <= (state_n == S_CLKHI);
         busy   <= (state_n != S_IDLE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q    <= '0;
         hist_q     <= '0;
         match_q    <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         frame_done <= 1'b0;
         changed    <= 1'b0;
      end else begin
         frame_done <= commit_now;
         changed    <= commit_now && do_commit && (captured != data);
         if (sample_now)
            shift_q <= captured;
         if (commit_now) begin
            hist_q  <= captured;
            match_q <= match_n;
            if (do_commit) begin
               data       <= captured;
               data_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_driver_74lv165_chain.sv
// Bench for driver_74lv165_chain: two instances (defaults, and DIV=3/FILT=3) fed by 74LV165
// models, checked every cycle against a frame-position / filter-window reference model.
module tb_driver_74lv165_chain;
   localparam int W  = 24;
   localparam int NA = 3;
   localparam int NB = 2;
   localparam int XW = 72;

   logic clk = 1'b0;
   logic reset, enable, oneshot, start;
   always #5 clk = ~clk;

   logic              sh_ldn_a, sclk_a, data_valid_a, frame_done_a, changed_a, busy_a;
   logic [NA-1:0]     qh_a;
   logic [NA*W-1:0]   data_a;
   logic [2:0]        state_a;
   logic              sh_ldn_b, sclk_b, data_valid_b, frame_done_b, changed_b, busy_b;
   logic [NB-1:0]     qh_b;
   logic [NB*W-1:0]   data_b;
   logic [2:0]        state_b;

   driver_74lv165_chain #(.N_CH(NA), .WIDTH(W), .DIV(1), .FILT(1)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .oneshot(oneshot), .start(start),
      .sh_ldn(sh_ldn_a), .sclk(sclk_a), .qh(qh_a), .data(data_a), .data_valid(data_valid_a),
      .frame_done(frame_done_a), .changed(changed_a), .busy(busy_a), .state_dbg(state_a));

   driver_74lv165_chain #(.N_CH(NB), .WIDTH(W), .DIV(3), .FILT(3)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .oneshot(oneshot), .start(start),
      .sh_ldn(sh_ldn_b), .sclk(sclk_b), .qh(qh_b), .data(data_b), .data_valid(data_valid_b),
      .frame_done(frame_done_b), .changed(changed_b), .busy(busy_b), .state_dbg(state_b));

   int n_checks = 0;
   int n_fail   = 0;
   int fd_cnt_a = 0;
   int fd_cnt_b = 0;
   int chg_b_cnt = 0;
   logic b_alt, rnd_a, rnd_b;

   // 74LV165 chain models: parallel load while SH/LD# low, shift on each CLK rise
   logic [W-1:0] par_a [NA];
   logic [W-1:0] sr_a  [NA];
   logic [W-1:0] par_b [NB];
   logic [W-1:0] sr_b  [NB];
   logic         sclk_a_d, sclk_b_d;

   always @(negedge clk) begin
      for (int c = 0; c < NA; c++)
         if (!sh_ldn_a) sr_a[c] <= par_a[c];
         else if (sclk_a && !sclk_a_d) sr_a[c] <= {sr_a[c][W-2:0], 1'b0};
      for (int c = 0; c < NB; c++)
         if (!sh_ldn_b) sr_b[c] <= par_b[c];
         else if (sclk_b && !sclk_b_d) sr_b[c] <= {sr_b[c][W-2:0], 1'b0};
      sclk_a_d <= sclk_a;
      sclk_b_d <= sclk_b;
   end

   always_comb begin
      for (int c = 0; c < NA; c++) qh_a[c] = sr_a[c][W-1];
      for (int c = 0; c < NB; c++) qh_b[c] = sr_b[c][W-1];
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkd(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position within the frame, plus a window of the latest captured frames
   int            m_pos   [2];
   int            m_cnt   [2];
   logic [XW-1:0] m_frame [2];
   logic [XW-1:0] m_data  [2];
   logic          m_valid [2];
   logic          m_chg   [2];
   logic [XW-1:0] m_win   [2][4];

   function automatic int div_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int filt_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic model_reset(input int d);
      m_pos[d] = -1; m_cnt[d] = 1; m_data[d] = '0; m_frame[d] = '0;
      m_valid[d] = 1'b0; m_chg[d] = 1'b0;
      for (int i = 0; i < 4; i++) m_win[d][i] = '0;
   endtask

   task automatic model_commit(input int d);
      bit same;
      same = 1'b1;
      for (int i = 3; i > 0; i--) m_win[d][i] = m_win[d][i-1];
      m_win[d][0] = m_frame[d];
      if (m_cnt[d] < 4) m_cnt[d]++;
      for (int i = 1; i < filt_of(d); i++)
         if (m_win[d][i] != m_win[d][0]) same = 1'b0;
      m_chg[d] = 1'b0;
      if (same && m_cnt[d] >= filt_of(d)) begin
         m_chg[d]   = (m_frame[d] != m_data[d]);
         m_data[d]  = m_frame[d];
         m_valid[d] = 1'b1;
      end
   endtask

   task automatic model_step(input int d);
      int last;
      last = 2 * W * div_of(d);
      if (m_pos[d] == div_of(d) - 1)
         m_frame[d] = (d == 0) ? {par_a[2], par_a[1], par_a[0]} : {24'h0, par_b[1], par_b[0]};
      if (m_pos[d] < 0) begin
         if (enable && (!oneshot || start)) m_pos[d] = 0;
      end else if (m_pos[d] == last)
         m_pos[d] = (enable && !oneshot) ? 0 : -1;
      else
         m_pos[d]++;
      if (m_pos[d] == last) model_commit(d);
   endtask

   task automatic check_dut(input int d, input logic sl, input logic sk, input logic fd,
                            input logic ch, input logic bz, input logic dv,
                            input logic [XW-1:0] dat);
      int p, dd, last;
      string pre;
      pre  = (d == 0) ? "a." : "b.";
      p    = m_pos[d];
      dd   = div_of(d);
      last = 2 * W * dd;
      chk1({pre, "busy"}, bz, p >= 0);
      chk1({pre, "sh_ldn"}, sl, !(p >= 0 && p < dd));
      chk1({pre, "sclk"}, sk, (p >= dd) && (p < last) && ((((p - dd) / dd) % 2) == 1));
      chk1({pre, "frame_done"}, fd, p == last);
      chk1({pre, "changed"}, ch, (p == last) && m_chg[d]);
      chk1({pre, "data_valid"}, dv, m_valid[d]);
      chkd({pre, "data"}, dat, m_data[d]);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         model_reset(0);
         model_reset(1);
      end
      check_dut(0, sh_ldn_a, sclk_a, frame_done_a, changed_a, busy_a, data_valid_a, data_a);
      check_dut(1, sh_ldn_b, sclk_b, frame_done_b, changed_b, busy_b, data_valid_b,
                {24'h0, data_b});
      if (!reset) begin
         model_step(0);
         model_step(1);
      end
      if (frame_done_a) fd_cnt_a++;
      if (frame_done_b) fd_cnt_b++;
      if (changed_b) chg_b_cnt++;
   end

   // Driver: one clock step, inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (b_alt && frame_done_b) par_b[0] = (par_b[0] == 24'h1) ? 24'h2 : 24'h1;
      if (rnd_a && $urandom_range(0, 15) == 0) par_a[$urandom_range(0, NA-1)] = W'($urandom);
      if (rnd_b && $urandom_range(0, 31) == 0) par_b[$urandom_range(0, NB-1)] = W'($urandom);
   endtask

   task automatic wait_fd(input int d, input int budget, input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!((d == 0) ? frame_done_a : frame_done_b) && n < budget);
      chk1({name, ".frame_done"}, (d == 0) ? frame_done_a : frame_done_b, 1'b1);
   endtask

   task automatic wait_idle(input int d, input int budget, input string name);
      int n;
      n = 0;
      while (((d == 0) ? busy_a : busy_b) && n < budget) begin
         tick();
         n++;
      end
      chk1({name, ".idle"}, (d == 0) ? busy_a : busy_b, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lo, rises, f0, b0;
      logic prev;
      reset = 1'b1; enable = 1'b0; oneshot = 1'b0; start = 1'b0;
      b_alt = 1'b1; rnd_a = 1'b0; rnd_b = 1'b0;
      par_a[0] = 24'hA5C30F; par_a[1] = 24'h123456; par_a[2] = 24'hFFFFFF;
      par_b[0] = 24'h000001; par_b[1] = 24'h000000;
      repeat (3) tick();
      chk1("rst.sh_ldn_a", sh_ldn_a, 1'b1);
      chk1("rst.sclk_a", sclk_a, 1'b0);
      chk1("rst.busy_a", busy_a, 1'b0);
      chk1("rst.valid_a", data_valid_a, 1'b0);
      chkd("rst.data_a", data_a, '0);
      reset = 1'b0;
      tick();
      chk1("idle.busy_a", busy_a, 1'b0);

      // continuous scan: first frame_done 49 cycles after enable for DIV=1
      enable = 1'b1;
      repeat (48) tick();
      chk1("t1.fd_a_c48", frame_done_a, 1'b0);
      tick();
      chk1("t1.fd_a_c49", frame_done_a, 1'b1);
      chkd("t1.data_a", data_a, 72'hFFFFFF_123456_A5C30F);
      chk1("t1.changed_a", changed_a, 1'b1);
      chk1("t1.valid_a", data_valid_a, 1'b1);
      repeat (49) tick();
      chk1("t1.fd_a_c98", frame_done_a, 1'b1);
      chk1("t1.changed_a_2nd", changed_a, 1'b0);
      repeat (46) tick();
      chk1("t2.fd_b_c144", frame_done_b, 1'b0);
      tick();
      chk1("t2.fd_b_c145", frame_done_b, 1'b1);
      chk1("t3.valid_b_1st", data_valid_b, 1'b0);

      // DIV=3 waveform over one back-to-back frame
      rnd_a = 1'b1;
      lo = 0; rises = 0; prev = sclk_b;
      for (int i = 1; i <= 145; i++) begin
         tick();
         if (!sh_ldn_b) lo++;
         if (sclk_b && !prev) rises++;
         prev = sclk_b;
         if (i == 144) chk1("t2.fd_b_next_c144", frame_done_b, 1'b0);
      end
      chk1("t2.fd_b_next_c145", frame_done_b, 1'b1);
      chkd("t2.ldn_low_cycles", 72'(lo), 72'd3);
      chkd("t2.sclk_pulses", 72'(rises), 72'd23);

      // FILT=3 with alternating frames never commits
      wait_fd(1, 200, "t3.alt1");
      wait_fd(1, 200, "t3.alt2");
      chk1("t3.valid_b_alt", data_valid_b, 1'b0);
      chkd("t3.data_b_alt", {24'h0, data_b}, '0);
      chkd("t3.changed_b_count", 72'(chg_b_cnt), 72'd0);
      b_alt = 1'b0;
      par_b[0] = 24'h00AA55;
      par_b[1] = 24'h000000;
      wait_fd(1, 200, "t3.hold1");
      chk1("t3.valid_b_h1", data_valid_b, 1'b0);
      wait_fd(1, 200, "t3.hold2");
      chk1("t3.valid_b_h2", data_valid_b, 1'b0);
      wait_fd(1, 200, "t3.hold3");
      chk1("t3.changed_b_h3", changed_b, 1'b1);
      chk1("t3.valid_b_h3", data_valid_b, 1'b1);
      chkd("t3.data_b_h3", {24'h0, data_b}, 72'h000000_000000_00AA55);

      // enable dropped mid-frame: frame completes, then idle
      wait_fd(0, 60, "t6.sync");
      repeat (10) tick();
      enable = 1'b0;
      f0 = fd_cnt_a;
      wait_fd(0, 60, "t6.finish");
      wait_idle(1, 200, "t6.b");
      repeat (30) tick();
      chk1("t6.busy_a", busy_a, 1'b0);
      chk1("t6.sh_ldn_a", sh_ldn_a, 1'b1);
      chkd("t6.fd_count_a", 72'(fd_cnt_a - f0), 72'd1);

      // oneshot: no start keeps idle; one start gives one frame; mid-frame start ignored
      oneshot = 1'b1;
      enable = 1'b1;
      repeat (20) tick();
      chk1("t4.busy_a_nostart", busy_a, 1'b0);
      chk1("t4.sh_ldn_a_nostart", sh_ldn_a, 1'b1);
      chk1("t4.sclk_a_nostart", sclk_a, 1'b0);
      chk1("t4.busy_b_nostart", busy_b, 1'b0);
      f0 = fd_cnt_a;
      b0 = fd_cnt_b;
      start = 1'b1; tick(); start = 1'b0;
      repeat (10) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (200) tick();
      chkd("t4.fd_count_a", 72'(fd_cnt_a - f0), 72'd1);
      chkd("t4.fd_count_b", 72'(fd_cnt_b - b0), 72'd1);
      chk1("t4.busy_a_after", busy_a, 1'b0);
      chk1("t4.busy_b_after", busy_b, 1'b0);

      // asynchronous reset at cycle 20 of a frame
      oneshot = 1'b0;
      rnd_a = 1'b0;
      wait_fd(0, 60, "t5.sync");
      repeat (20) tick();
      #2 reset = 1'b1;
      #1;
      chk1("t5.sh_ldn_a", sh_ldn_a, 1'b1);
      chk1("t5.sclk_a", sclk_a, 1'b0);
      chk1("t5.busy_a", busy_a, 1'b0);
      chk1("t5.valid_a", data_valid_a, 1'b0);
      chkd("t5.data_a", data_a, '0);
      chk1("t5.busy_b", busy_b, 1'b0);
      chk1("t5.valid_b", data_valid_b, 1'b0);
      chkd("t5.data_b", {24'h0, data_b}, '0);
      par_a[0] = 24'hC0FFEE; par_a[1] = 24'h00FF00; par_a[2] = 24'h0F0F0F;
      tick();
      tick();
      reset = 1'b0;
      wait_fd(0, 60, "t5.after");
      chkd("t5.data_a_after", data_a, 72'h0F0F0F_00FF00_C0FFEE);
      chk1("t5.changed_a_after", changed_a, 1'b1);
      chk1("t5.valid_a_after", data_valid_a, 1'b1);

      // randomized control and data, checked every cycle by the model
      rnd_a = 1'b1;
      rnd_b = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         if ($urandom_range(0, 149) == 0) oneshot = ~oneshot;
         start = ($urandom_range(0, 9) == 0);
         tick();
      end
      start = 1'b0;
      enable = 1'b0;
      wait_idle(0, 200, "end.a");
      wait_idle(1, 400, "end.b");
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
